// File: rtl/hough_pkg.sv
// Shared state encoding and engine bit indices for the Hough frame controller.
package hough_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_VOTE   = 3'd2,
        ST_PEAK   = 3'd3,
        ST_REPORT = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam int unsigned ENG_CLR  = 0;
    localparam int unsigned ENG_VOTE = 1;
    localparam int unsigned ENG_PEAK = 2;

endpackage

// File: rtl/hough_frame_ctrl.sv
// Frame sequencer: runs clear -> vote -> peak engines per edge frame, reports
// results, counts completed/dropped frames and watchdogs each engine phase.
module hough_frame_ctrl
    import hough_pkg::*;
#(
    parameter int unsigned TIMEOUT_W   = 24,
    parameter int unsigned TIMEOUT_MAX = 2**24-1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_rdy,
    input  logic        abort,
    input  logic        err_clr,
    input  logic        res_ack,
    input  logic [2:0]  eng_done,
    output logic [2:0]  eng_start,
    output logic        eng_abort,
    output logic [2:0]  acc_gnt,
    output logic        busy,
    output logic [2:0]  phase,
    output logic        res_valid,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic        err,
    output logic [1:0]  err_phase
);

    state_t               state;
    state_t               state_nxt;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 wdog_hit;
    logic [2:0]           start_nxt;
    logic                 abort_nxt;
    logic                 timeout;
    logic                 frame_done;
    logic [1:0]           tmo_phase;

    // Watchdog reads cycles already spent; the hit fires on the edge that
    // completes cycle number TIMEOUT_MAX of the phase.
    assign wdog_hit = (wdog == TIMEOUT_W'(TIMEOUT_MAX - 1));
    assign phase    = state;

    always_comb begin
        state_nxt  = state;
        start_nxt  = '0;
        abort_nxt  = 1'b0;
        timeout    = 1'b0;
        frame_done = 1'b0;
        tmo_phase  = 2'd0;
        case (state)
            ST_IDLE:   if (frame_rdy) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if (eng_done[ENG_CLR]) state_nxt = ST_VOTE;
                else if (wdog_hit) begin timeout = 1'b1; tmo_phase = 2'd0; end
            end
            ST_VOTE: begin
                if (eng_done[ENG_VOTE]) state_nxt = ST_PEAK;
                else if (wdog_hit) begin timeout = 1'b1; tmo_phase = 2'd1; end
            end
            ST_PEAK: begin
                if (eng_done[ENG_PEAK]) state_nxt = ST_REPORT;
                else if (wdog_hit) begin timeout = 1'b1; tmo_phase = 2'd2; end
            end
            ST_REPORT: if (res_ack) begin state_nxt = ST_IDLE; frame_done = 1'b1; end
            ST_ERROR:  if (err_clr) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        if (timeout) begin
            state_nxt = ST_ERROR;
            abort_nxt = 1'b1;
        end

        // Abort overrides every other decision taken above.
        if (abort && (state inside {ST_CLEAR, ST_VOTE, ST_PEAK, ST_REPORT})) begin
            state_nxt  = ST_IDLE;
            abort_nxt  = 1'b1;
            timeout    = 1'b0;
            frame_done = 1'b0;
        end

        if (state_nxt != state) begin
            case (state_nxt)
                ST_CLEAR: start_nxt[ENG_CLR]  = 1'b1;
                ST_VOTE:  start_nxt[ENG_VOTE] = 1'b1;
                ST_PEAK:  start_nxt[ENG_PEAK] = 1'b1;
                default:  start_nxt = '0;
            endcase
        end
    end

    always_comb begin
        acc_gnt = '0;
        case (state)
            ST_CLEAR: acc_gnt[ENG_CLR]  = 1'b1;
            ST_VOTE:  acc_gnt[ENG_VOTE] = 1'b1;
            ST_PEAK:  acc_gnt[ENG_PEAK] = 1'b1;
            default:  acc_gnt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wdog      <= '0;
            eng_start <= '0;
            eng_abort <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            err_phase <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            eng_start <= start_nxt;
            eng_abort <= abort_nxt;
            busy      <= (state_nxt inside {ST_CLEAR, ST_VOTE, ST_PEAK, ST_REPORT});
            res_valid <= (state_nxt == ST_REPORT);

            if (state_nxt != state)
                wdog <= '0;
            else if (state inside {ST_CLEAR, ST_VOTE, ST_PEAK})
                wdog <= wdog + 1'b1;

            if (timeout) begin
                err       <= 1'b1;
                err_phase <= tmo_phase;
            end else if (state == ST_ERROR && err_clr) begin
                err <= 1'b0;
            end

            if (frame_done)
                frame_cnt <= frame_cnt + 1'b1;

            if (frame_rdy && state != ST_IDLE && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
